pipeline_skid_register: RTL and testbench
=========================================

Name: pipeline_skid_register

Overview:
- Parametrised successor to the fixed-width fetch/decode stage register.
- Carries a PC/instruction pair between two pipeline stages using a valid/ready handshake instead of a bare enable.
- A 2-entry skid buffer gives full throughput while keeping in_ready registered, so there is no combinational path from out_ready to in_ready.
- Synchronous flush turns the stage into a bubble: empty stage, NOP on the instruction bus.

Parameters:
- PC_W, 32, width of in_pc/out_pc (XLEN of the core).
- INSTR_W, 32, width of in_instr/out_instr.
- NOP_INSTR, 32'h00000013, instruction value presented when the stage is empty, flushed or reset (addi x0,x0,0).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high reset.
- flush, input, 1, synchronous squash of all held and incoming entries.
- in_valid, input, 1, upstream presents in_pc/in_instr.
- in_ready, output, 1, stage can accept; registered.
- in_pc, input, PC_W, upstream PC.
- in_instr, input, INSTR_W, upstream instruction.
- out_valid, output, 1, out_pc/out_instr hold a live entry.
- out_ready, input, 1, downstream accepts.
- out_pc, output, PC_W, PC of the head entry.
- out_instr, output, INSTR_W, instruction of the head entry.
- occupancy, output, 2, number of held entries (0..2).

Behaviour:
- Storage and handshake:
  - Two entries: main (drives the out_* ports) and skid.
  - Accept in = in_valid && in_ready. Accept out = out_valid && out_ready.
- State machine (state is registered; occupancy = state encoding):
  - EMPTY (0):
    - out_valid=0, in_ready=1.
    - Accept in -> ONE, main <= in.
  - ONE (1):
    - out_valid=1, in_ready=1.
    - Accept in and accept out -> ONE, main <= in.
    - Accept in only -> FULL, skid <= in.
    - Accept out only -> EMPTY, main payload <= {0, NOP_INSTR}.
    - Neither -> hold.
  - FULL (2):
    - out_valid=1, in_ready=0.
    - Accept out -> ONE, main <= skid.
    - Otherwise hold.
    - in_valid is ignored in this state.
- Timing:
  - Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N, when the stage was EMPTY or draining.
  - Steady-state throughput is 1 entry/cycle while out_ready=1.
- Ordering and stability:
  - Strict FIFO order; no entry is ever duplicated or dropped except by flush.
  - While out_valid=1 and out_ready=0, out_pc/out_instr stay bit-stable.
- Flush:
  - Synchronous; highest priority over all handshake events in the same cycle.
  - Next state EMPTY, main payload <= {0, NOP_INSTR}, skid payload <= {0, NOP_INSTR}.
  - An in_valid beat coinciding with flush is discarded even if in_ready=1.
  - An out accept coinciding with flush is a normal consumption by downstream; the stage is still emptied.
- Reset:
  - Asynchronous, including mid-transfer.
  - State EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - out_pc=0, out_instr=NOP_INSTR, skid payload cleared.
  - Recovery: first accept is possible on the first rising edge after reset deasserts.
- Output and width rules:
  - in_ready is a direct decode of the registered state (state != FULL).
  - out_valid likewise (state != EMPTY).
  - When empty, out_pc=0 and out_instr=NOP_INSTR, so a stalled downstream decoder sees a harmless instruction.
  - Payloads are copied verbatim; no arithmetic.
  - Widths are independent; any PC_W >= 1 and INSTR_W >= 1 is legal.
  - NOP_INSTR is truncated or zero-extended to INSTR_W.

Test Plan:
- Reset state: assert reset asynchronously between edges with the stage FULL -> immediately out_valid=0, in_ready=1, occupancy=0, out_pc=0, out_instr=32'h00000013.
- Streaming: out_ready=1, present 4 beats pc=0x00,0x04,0x08,0x0C / instr=0x00500093,0x00100113,0x002081B3,0x00000013 on consecutive cycles -> same sequence on out_* one cycle later; in_ready stays 1; occupancy stays <= 1.
- Backpressure/skid: out_ready=0, present pc=0x100 then pc=0x104 -> occupancy 1 then 2, in_ready=0, out_pc holds 0x100; a third beat pc=0x108 held on in_* is not taken; release out_ready -> out 0x100, 0x104, 0x108 in order, no loss or duplicate.
- Flush priority: stage FULL (0x200, 0x204), flush=1 together with in_valid=1 (pc=0x208) -> next cycle occupancy=0, out_valid=0, out_instr=0x00000013; 0x208 never appears on the output.
- Simultaneous in/out in ONE: hold 0x300, assert out_ready=1 and in_valid=1 (pc=0x304) -> next cycle out_pc=0x304, occupancy=1.
- Parameter sweep: PC_W=64, INSTR_W=16, NOP_INSTR=16'h0001 -> reset/flush output 16'h0001; a 64-bit pc 0xFFFF_FFFF_0000_0004 passes through unmodified.

Source files
------------

// File: rtl/pipeline_skid_register.sv
// ---------------------------------------------------------------------------
// pipeline_skid_register
//
// Carries a PC/instruction pair from one pipeline stage to the next over a
// valid/ready handshake. Two entries are held: main drives the out_* ports and
// skid catches the one beat that arrives in the cycle downstream stalls. This
// keeps in_ready a pure decode of registered state, with no combinational path
// from out_ready, while still sustaining one entry per cycle.
// A synchronous flush empties the stage. The empty stage shows pc=0 and a NOP.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   flush      in   synchronous squash of held and incoming entries
//   in_valid   in   upstream presents in_pc/in_instr
//   in_ready   out  stage can accept (registered decode)
//   in_pc      in   [PC_W-1:0]     upstream PC
//   in_instr   in   [INSTR_W-1:0]  upstream instruction
//   out_valid  out  out_pc/out_instr hold a live entry
//   out_ready  in   downstream accepts
//   out_pc     out  [PC_W-1:0]     PC of the head entry
//   out_instr  out  [INSTR_W-1:0]  instruction of the head entry
//   occupancy  out  [1:0]          number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipeline_skid_register #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  // The NOP is truncated or zero-extended to the instruction width.
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  // The encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [PC_W-1:0]    main_pc,    skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic               acc_in, acc_out;

  assign acc_in  = in_valid  && in_ready;
  assign acc_out = out_valid && out_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next-state logic. Flush dominates every handshake event.
  // NOTE: the default assignment first keeps this block free of inferred
  // latches on any path the case statement does not cover.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (acc_in) state_next = ONE;
        ONE: begin
          if (acc_in && !acc_out)      state_next = FULL;
          else if (!acc_in && acc_out) state_next = EMPTY;
        end
        FULL:  if (acc_out) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Payload registers. in_valid is ignored in FULL because in_ready is low,
  // so acc_in already excludes it.
  // NOTE: the payload is reset (not left undefined) so an empty or reset
  // stage presents pc=0 and a NOP to a decoder that ignores out_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_pc    <= '0;
      main_instr <= NOP;
      skid_pc    <= '0;
      skid_instr <= NOP;
    end else if (flush) begin
      main_pc    <= '0;
      main_instr <= NOP;
      skid_pc    <= '0;
      skid_instr <= NOP;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc_in) begin
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end
        end
        ONE: begin
          if (acc_in && acc_out) begin
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end else if (acc_in) begin
            // Downstream stalled: park the new beat behind the head.
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
          end else if (acc_out) begin
            main_pc    <= '0;
            main_instr <= NOP;
          end
        end
        FULL: begin
          if (acc_out) begin
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure decodes of registered state and the main entry.
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    occupancy = state;
    out_pc    = main_pc;
    out_instr = main_instr;
  end

endmodule

// File: tb/tb_pipeline_skid_register.sv
// ---------------------------------------------------------------------------
// tb_pipeline_skid_register
//
// The reference model is a plain FIFO of accepted entries. The driver pushes
// each beat the stage accepts, and flush clears the FIFO. A separate monitor
// compares the DUT against that FIFO on every falling edge: occupancy equals
// the FIFO depth, in_ready means fewer than two entries are held, and the
// output shows the FIFO head, or pc=0/NOP when the FIFO is empty. A second
// instance with 64-bit PC, 16-bit instructions and NOP 16'h0001 covers the
// width parameters.
// ---------------------------------------------------------------------------
module tb_pipeline_skid_register;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [1:0]  occupancy;

  logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [63:0] w_in_pc, w_out_pc;
  logic [15:0] w_in_instr, w_out_instr;
  logic [1:0]  w_occupancy;

  entry_t model_q[$];
  int     checks   = 0;
  int     failures = 0;

  always #5 clock = ~clock;

  pipeline_skid_register dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .occupancy (occupancy)
  );

  pipeline_skid_register #(
    .PC_W      (64),
    .INSTR_W   (16),
    .NOP_INSTR (32'h0000_0001)
  ) dut_w (
    .clock     (clock),
    .reset     (reset),
    .flush     (w_flush),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_pc     (w_in_pc),
    .in_instr  (w_in_instr),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_pc    (w_out_pc),
    .out_instr (w_out_instr),
    .occupancy (w_occupancy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus; the model records the beat if the stage
  // accepts it at the coming rising edge. Returns 1ns after that edge.
  task automatic drive_cycle(input logic v, input logic [31:0] p, input logic [31:0] i,
                             input logic f, input logic r);
    in_valid  = v;
    in_pc     = p;
    in_instr  = i;
    flush     = f;
    out_ready = r;
    @(negedge clock);
    #1;
    if (in_valid && in_ready && !flush) model_q.push_back('{pc: p, instr: i});
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares against the model and retires consumed entries.
  always @(negedge clock) begin
    if (!reset) begin
      check("occupancy", 64'(occupancy), 64'(model_q.size()));
      check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        check("out_pc", 64'(out_pc), 64'(model_q[0].pc));
        check("out_instr", 64'(out_instr), 64'(model_q[0].instr));
        if (out_ready) void'(model_q.pop_front());
      end else begin
        check("empty_pc", 64'(out_pc), 64'd0);
        check("empty_instr", 64'(out_instr), 64'(NOP));
      end
      if (flush) model_q.delete();
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_pc = '0; w_in_instr = '0;

    // Reset state of both instances, then release between edges so the very
    // next rising edge must accept a beat.
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_instr", 64'(out_instr), 64'(NOP));
    check("w_rst_instr", 64'(w_out_instr), 64'h0001);
    check("w_rst_pc", w_out_pc, 64'd0);
    @(posedge clock); #3;
    reset = 1'b0;
    drive_cycle(1'b1, 32'h0000_0040, 32'h0000_0093, 1'b0, 1'b1);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Streaming at full rate.
    drive_cycle(1'b1, 32'h00, 32'h0050_0093, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h04, 32'h0010_0113, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h08, 32'h0020_81B3, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h0C, 32'h0000_0013, 1'b0, 1'b1);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Backpressure into the skid entry; third beat waits on the inputs.
    drive_cycle(1'b1, 32'h100, 32'hA100, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h104, 32'hA104, 1'b0, 1'b0);
    check("skid_occ", 64'(occupancy), 64'd2);
    check("skid_head", 64'(out_pc), 64'h100);
    drive_cycle(1'b1, 32'h108, 32'hA108, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h108, 32'hA108, 1'b0, 1'b0);
    check("skid_hold", 64'(out_pc), 64'h100);
    drive_cycle(1'b1, 32'h108, 32'hA108, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("drained_occ", 64'(occupancy), 64'd0);

    // Flush while FULL with a coinciding input beat.
    drive_cycle(1'b1, 32'h200, 32'hB200, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h204, 32'hB204, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h208, 32'hB208, 1'b1, 1'b0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_instr", 64'(out_instr), 64'(NOP));
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Simultaneous accept in and out while holding one entry.
    drive_cycle(1'b1, 32'h300, 32'hC300, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h304, 32'hC304, 1'b0, 1'b1);
    check("swap_pc", 64'(out_pc), 64'h304);
    check("swap_occ", 64'(occupancy), 64'd1);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset between edges with the stage FULL.
    drive_cycle(1'b1, 32'h400, 32'hD400, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h404, 32'hD404, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_q.delete();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_pc", 64'(out_pc), 64'd0);
    check("arst_instr", 64'(out_instr), 64'(NOP));
    reset = 1'b0;
    drive_cycle(1'b1, 32'h500, 32'hE500, 1'b0, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Randomised traffic with occasional flush.
    for (int k = 0; k < 400; k++)
      drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("final_occ", 64'(occupancy), 64'd0);

    // Wide instance: 64-bit PC passes through verbatim; flush shows its NOP.
    w_in_valid = 1'b1;
    w_in_pc    = 64'hFFFF_FFFF_0000_0004;
    w_in_instr = 16'h1234;
    @(posedge clock); #1;
    w_in_valid = 1'b0;
    check("w_valid", 64'(w_out_valid), 64'd1);
    check("w_pc", w_out_pc, 64'hFFFF_FFFF_0000_0004);
    check("w_instr", 64'(w_out_instr), 64'h1234);
    w_flush = 1'b1;
    @(posedge clock); #1;
    w_flush = 1'b0;
    check("w_flush_valid", 64'(w_out_valid), 64'd0);
    check("w_flush_pc", w_out_pc, 64'd0);
    check("w_flush_instr", 64'(w_out_instr), 64'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
